// File: rtl/ufp_line_responder.sv
// Single-line buffer responder for the ufp word interface. Read hits are served
// from the buffer, misses fill over dfp, and writes merge in and write through.
module ufp_line_responder #(
    parameter int unsigned LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          ufp_addr,
    input  logic [3:0]           ufp_rmask,
    input  logic [3:0]           ufp_wmask,
    input  logic [31:0]          ufp_wdata,
    output logic [31:0]          ufp_rdata,
    output logic                 ufp_resp,
    input  logic                 inv,
    output logic [31:0]          dfp_addr,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [LINE_BITS-1:0] dfp_wdata,
    input  logic [LINE_BITS-1:0] dfp_rdata,
    input  logic                 dfp_resp
);

    localparam int unsigned LINE_BYTES = LINE_BITS / 8;
    localparam int unsigned OFS        = $clog2(LINE_BYTES);
    localparam int unsigned TAG_W      = 32 - OFS;
    localparam int unsigned WSEL_W     = OFS - 2;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WRITE,
        DONE
    } state_t;

    state_t state, state_next;

    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic [LINE_BITS-1:0] line;
    logic [31:2]          req_addr;
    logic [3:0]           req_wmask;
    logic [31:0]          req_wdata;

    logic                 req_write;
    logic                 req_any;
    logic                 hit;
    logic [WSEL_W-1:0]    wsel;
    logic [31:0]          word_base;
    logic [31:0]          sel_word;
    logic [LINE_BITS-1:0] merged_line;
    logic                 addr_lsb_unused;

    assign addr_lsb_unused = ^ufp_addr[1:0];

    assign req_any   = (|ufp_rmask) || (|ufp_wmask);
    assign req_write = |req_wmask;
    assign hit       = valid && (tag == req_addr[31:OFS]);
    assign wsel      = req_addr[OFS-1:2];
    assign word_base = {{(27 - WSEL_W){1'b0}}, wsel, 5'b0};
    assign sel_word  = line[word_base +: 32];

    always_comb begin
        merged_line = line;
        for (int unsigned b = 0; b < 4; b++) begin
            if (req_wmask[b]) begin
                merged_line[word_base + b * 8 +: 8] = req_wdata[b * 8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_any) state_next = LOOKUP;
            LOOKUP:  state_next = hit ? (req_write ? WRITE : DONE) : FILL;
            FILL:    if (dfp_resp) state_next = LOOKUP;
            WRITE:   if (dfp_resp) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dfp_read  = 1'b0;
        dfp_write = 1'b0;
        dfp_addr  = '0;
        dfp_wdata = '0;
        ufp_resp  = 1'b0;
        ufp_rdata = '0;
        unique case (state)
            FILL: begin
                dfp_read = 1'b1;
                dfp_addr = {req_addr[31:OFS], {OFS{1'b0}}};
            end
            WRITE: begin
                dfp_write = 1'b1;
                dfp_addr  = {req_addr[31:OFS], {OFS{1'b0}}};
                dfp_wdata = line;
            end
            DONE: begin
                ufp_resp = 1'b1;
                if (!req_write) ufp_rdata = sel_word;
            end
            default: ;
        endcase
    end

    // inv is applied last so it wins over a coincident fill; the request then refills.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            tag       <= '0;
            line      <= '0;
            req_addr  <= '0;
            req_wmask <= '0;
            req_wdata <= '0;
        end else begin
            if (state == IDLE && req_any) begin
                req_addr  <= ufp_addr[31:2];
                req_wmask <= ufp_wmask;
                req_wdata <= ufp_wdata;
            end
            if (state == LOOKUP && hit && req_write) begin
                line <= merged_line;
            end
            if (state == FILL && dfp_resp) begin
                line  <= dfp_rdata;
                tag   <= req_addr[31:OFS];
                valid <= 1'b1;
            end
            if (inv) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
